// File: rtl/relogio_pkg.sv
// Shared constants for the clock time-setting controller: state encoding,
// BCD limits and a capture-sanity helper.
package relogio_pkg;

  localparam int BCD_W    = 4;
  localparam int HORA_MAX = 23;
  localparam int MIN_MAX  = 59;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_SET_H  = 2'b01;
  localparam logic [1:0] ST_SET_M  = 2'b10;
  localparam logic [1:0] ST_COMMIT = 2'b11;

  localparam logic [BCD_W-1:0] HORA_MAX_D1 = BCD_W'(HORA_MAX / 10);
  localparam logic [BCD_W-1:0] HORA_MAX_D0 = BCD_W'(HORA_MAX % 10);
  localparam logic [BCD_W-1:0] MIN_MAX_D1  = BCD_W'(MIN_MAX / 10);
  localparam logic [BCD_W-1:0] MIN_MAX_D0  = BCD_W'(MIN_MAX % 10);
  localparam logic [BCD_W-1:0] BCD_NINE    = BCD_W'(9);

  // True when a live BCD time is a legal HH:MM value; checked digit-wise in BCD.
  function automatic logic bcd_time_ok(input logic [1:0]       h1,
                                       input logic [BCD_W-1:0] h0,
                                       input logic [BCD_W-1:0] m1,
                                       input logic [BCD_W-1:0] m0);
    logic             ok_h;
    logic [BCD_W-1:0] h1_w;
    h1_w = {2'b00, h1};
    if (h1_w < HORA_MAX_D1) begin
      ok_h = (h0 <= BCD_NINE);
    end else begin
      ok_h = (h1_w == HORA_MAX_D1) && (h0 <= HORA_MAX_D0);
    end
    return ok_h && (m1 <= MIN_MAX_D1) && (m0 <= BCD_NINE);
  endfunction

endpackage

// File: rtl/relogio_inc_bcd.sv
// Combinational two-digit BCD incrementer; wraps to 00 when the input equals
// the supplied maximum.
module relogio_inc_bcd
  import relogio_pkg::*;
#(
  parameter int W1 = 4
) (
  input  logic [W1-1:0]    d1_i,
  input  logic [BCD_W-1:0] d0_i,
  input  logic [W1-1:0]    max1_i,
  input  logic [BCD_W-1:0] max0_i,
  output logic [W1-1:0]    q1_o,
  output logic [BCD_W-1:0] q0_o
);

  // Next BCD value: wrap at max, otherwise carry from units into tens at 9.
  always_comb begin
    q1_o = d1_i;
    q0_o = d0_i;
    if ((d1_i == max1_i) && (d0_i == max0_i)) begin
      q1_o = W1'(0);
      q0_o = BCD_W'(0);
    end else if (d0_i >= BCD_NINE) begin
      q1_o = d1_i + W1'(1);
      q0_o = BCD_W'(0);
    end else begin
      q1_o = d1_i;
      q0_o = d0_i + BCD_W'(1);
    end
  end

endmodule

// File: rtl/relogio_ajuste.sv
// Time-setting controller: captures live time, steps hours then minutes from
// two buttons, and commits the edit to the clock core with a one-cycle LD_time.
module relogio_ajuste
  import relogio_pkg::*;
#(
  parameter int TIMEOUT_CYC = 150,
  parameter int BLINK_HALF  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [1:0]       cur_H1,
  input  logic [BCD_W-1:0] cur_H0,
  input  logic [BCD_W-1:0] cur_M1,
  input  logic [BCD_W-1:0] cur_M0,
  output logic [1:0]       H_in1,
  output logic [BCD_W-1:0] H_in0,
  output logic [BCD_W-1:0] M_in1,
  output logic [BCD_W-1:0] M_in0,
  output logic             LD_time,
  output logic [1:0]       modo,
  output logic             blink
);

  localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [1:0]       st_q, st_d;
  logic [1:0]       h1_q, h1_d;
  logic [BCD_W-1:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             blink_q, blink_d;
  logic             ld_q, ld_d;
  logic             mode_prev_q, inc_prev_q;
  logic             mode_press_s, inc_press_s;
  logic             entry_s, in_set_s;
  logic [1:0]       h1_inc_s;
  logic [BCD_W-1:0] h0_inc_s, m1_inc_s, m0_inc_s;

  assign mode_press_s = btn_mode & ~mode_prev_q;
  assign inc_press_s  = btn_inc & ~inc_prev_q;

  relogio_inc_bcd #(.W1(2)) u_inc_hora (
    .d1_i   (h1_q),
    .d0_i   (h0_q),
    .max1_i (HORA_MAX_D1[1:0]),
    .max0_i (HORA_MAX_D0),
    .q1_o   (h1_inc_s),
    .q0_o   (h0_inc_s)
  );

  relogio_inc_bcd #(.W1(BCD_W)) u_inc_min (
    .d1_i   (m1_q),
    .d0_i   (m0_q),
    .max1_i (MIN_MAX_D1),
    .max0_i (MIN_MAX_D0),
    .q1_o   (m1_inc_s),
    .q0_o   (m0_inc_s)
  );

  // Next state and edit registers; a mode press always beats an increment.
  always_comb begin
    st_d = st_q;
    h1_d = h1_q;
    h0_d = h0_q;
    m1_d = m1_q;
    m0_d = m0_q;
    case (st_q)
      ST_RUN: begin
        if (mode_press_s) begin
          st_d = ST_SET_H;
          if (bcd_time_ok(cur_H1, cur_H0, cur_M1, cur_M0)) begin
            h1_d = cur_H1;
            h0_d = cur_H0;
            m1_d = cur_M1;
            m0_d = cur_M0;
          end else begin
            h1_d = 2'd0;
            h0_d = BCD_W'(0);
            m1_d = BCD_W'(0);
            m0_d = BCD_W'(0);
          end
        end else begin
          st_d = ST_RUN;
        end
      end
      ST_SET_H: begin
        if (mode_press_s) begin
          st_d = ST_SET_M;
        end else if (inc_press_s) begin
          h1_d = h1_inc_s;
          h0_d = h0_inc_s;
        end else if (idle_q == IDLE_LAST) begin
          st_d = ST_RUN;
        end else begin
          st_d = ST_SET_H;
        end
      end
      ST_SET_M: begin
        if (mode_press_s) begin
          st_d = ST_COMMIT;
        end else if (inc_press_s) begin
          m1_d = m1_inc_s;
          m0_d = m0_inc_s;
        end else if (idle_q == IDLE_LAST) begin
          st_d = ST_RUN;
        end else begin
          st_d = ST_SET_M;
        end
      end
      ST_COMMIT: st_d = ST_RUN;
      default:   st_d = ST_RUN;
    endcase
  end

  // Idle timer, blink phase and commit strobe all follow the chosen next state.
  always_comb begin
    in_set_s = (st_d == ST_SET_H) || (st_d == ST_SET_M);
    entry_s  = in_set_s && (st_d != st_q);
    ld_d     = (st_d == ST_COMMIT);
    if (in_set_s) begin
      if (entry_s || mode_press_s || inc_press_s) begin
        idle_d = IW'(0);
      end else begin
        idle_d = idle_q + IW'(1);
      end
      if (entry_s || inc_press_s) begin
        blink_d = 1'b1;
        bcnt_d  = BW'(0);
      end else if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
        bcnt_d  = BW'(0);
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end else begin
      idle_d  = IW'(0);
      blink_d = 1'b0;
      bcnt_d  = BW'(0);
    end
  end

  // State, edit, timer and button-history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_RUN;
      h1_q        <= 2'd0;
      h0_q        <= BCD_W'(0);
      m1_q        <= BCD_W'(0);
      m0_q        <= BCD_W'(0);
      idle_q      <= IW'(0);
      bcnt_q      <= BW'(0);
      blink_q     <= 1'b0;
      ld_q        <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      idle_q      <= idle_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      ld_q        <= ld_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
    end
  end

  assign H_in1   = h1_q;
  assign H_in0   = h0_q;
  assign M_in1   = m1_q;
  assign M_in0   = m0_q;
  assign LD_time = ld_q;
  assign modo    = st_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_relogio_ajuste.sv
// Self-checking bench for relogio_ajuste: commits are scoreboarded, mode,
// blink and edit values are checked directly against bench-derived constants.
module tb_relogio_ajuste;

  localparam int TIMEOUT_CYC = 150;
  localparam int BLINK_HALF  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [1:0] cur_H1 = 2'd0;
  logic [3:0] cur_H0 = 4'd0, cur_M1 = 4'd0, cur_M0 = 4'd0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time;
  logic [1:0] modo;
  logic       blink;

  int total = 0;
  int bad = 0;
  int ld_cnt = 0;
  logic [13:0] exp_q[$];

  relogio_ajuste #(.TIMEOUT_CYC(TIMEOUT_CYC), .BLINK_HALF(BLINK_HALF)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .modo(modo), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every LD_time pulse must match the oldest pending commit.
  always @(negedge clk) begin
    if (LD_time === 1'b1) begin
      ld_cnt++;
      if (exp_q.size() == 0) begin
        chk("ld_unexpected", 32'd1, 32'd0);
      end else begin
        chk("ld_value", {H_in1, H_in0, M_in1, M_in0}, exp_q.pop_front());
      end
    end
  end

  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    cur_H1 = h1; cur_H0 = h0; cur_M1 = m1; cur_M0 = m0;
  endtask

  function automatic logic [5:0] hh();
    return {H_in1, H_in0};
  endfunction

  function automatic logic [7:0] mm();
    return {M_in1, M_in0};
  endfunction

  initial begin
    // Reset state
    #2;
    chk("rst_modo", modo, 2'b00);
    chk("rst_time", {hh(), mm()}, 14'd0);
    chk("rst_ld", LD_time, 1'b0);
    chk("rst_blink", blink, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 07:45 -> 13:00
    set_cur(2'd0, 4'd7, 4'd4, 4'd5);
    press(1'b1, 1'b0);
    chk("t1_modo_seth", modo, 2'b01);
    chk("t1_capture", {hh(), mm()}, {6'h07, 8'h45});
    chk("t1_blink_entry", blink, 1'b1);
    repeat (6) press(1'b0, 1'b1);
    chk("t1_hour13", hh(), 6'h13);
    press(1'b1, 1'b0);
    chk("t1_modo_setm", modo, 2'b10);
    repeat (15) press(1'b0, 1'b1);
    chk("t1_min00", mm(), 8'h00);
    chk("t1_hour_kept", hh(), 6'h13);
    exp_q.push_back({6'h13, 8'h00});
    press(1'b1, 1'b0);
    chk("t1_modo_commit", modo, 2'b11);
    chk("t1_ld_high", LD_time, 1'b1);
    @(negedge clk);
    chk("t1_modo_run", modo, 2'b00);
    chk("t1_ld_low", LD_time, 1'b0);

    // 23:59 wrap, no hour carry from minute wrap
    set_cur(2'd2, 4'd3, 4'd5, 4'd9);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t2_hour_wrap", hh(), 6'h00);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t2_min_wrap", mm(), 8'h00);
    chk("t2_no_carry", hh(), 6'h00);
    exp_q.push_back(14'd0);
    press(1'b1, 1'b0);
    @(negedge clk);

    // Timeout in SET_H
    set_cur(2'd1, 4'd0, 4'd2, 4'd0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("t3_hour12", hh(), 6'h12);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    chk("t3_still_seth", modo, 2'b01);
    @(negedge clk);
    chk("t3_timeout_run", modo, 2'b00);
    chk("t3_abandoned", {hh(), mm()}, {6'h12, 8'h20});
    chk("t3_blink_run", blink, 1'b0);

    // Simultaneous press, then held inc
    set_cur(2'd0, 4'd5, 4'd3, 4'd0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("t4_mode_wins", modo, 2'b10);
    chk("t4_hour_same", hh(), 6'h05);
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (20) @(negedge clk);
    btn_inc = 1'b0;
    chk("t4_held_once", mm(), 8'h31);
    exp_q.push_back({6'h05, 8'h31});
    press(1'b1, 1'b0);
    @(negedge clk);

    // Invalid capture and blink cadence
    set_cur(2'd2, 4'd7, 4'd6, 4'd8);
    press(1'b1, 1'b0);
    chk("t5_sanitised", {hh(), mm()}, 14'd0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t5_blink%0d", i), blink, (i < BLINK_HALF) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    chk("t5_blink_low", blink, 1'b0);
    press(1'b0, 1'b1);
    chk("t5_blink_forced", blink, 1'b1);
    chk("t5_hour01", hh(), 6'h01);
    press(1'b1, 1'b0);
    exp_q.push_back({6'h01, 8'h00});
    press(1'b1, 1'b0);
    @(negedge clk);
    chk("t5_blink_run", blink, 1'b0);

    // Reset mid SET_M, then normal operation
    set_cur(2'd1, 4'd2, 4'd3, 4'd4);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t6_in_setm", modo, 2'b10);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_modo", modo, 2'b00);
    chk("t6_rst_outs", {hh(), mm(), LD_time, blink}, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    set_cur(2'd0, 4'd8, 4'd1, 4'd5);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    exp_q.push_back({6'h09, 8'h16});
    press(1'b1, 1'b0);
    repeat (3) @(negedge clk);

    chk("sb_drained", exp_q.size(), 32'd0);
    chk("ld_count", ld_cnt, 32'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
